// File: rtl/counter_sequencer_pkg.sv
// counter_seq_pkg: state encoding shared by the counter sequencer files.
package counter_seq_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      PAUSE = ST_PAUSE,
      DONE  = ST_DONE
   } state_t;

endpackage

// File: rtl/counter_sequencer_prescale_tick.sv
// prescale_tick: programmable divider. tick is high while the counter sits at
// period, so the owner sees the step request in the same cycle it is taken.
module prescale_tick #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         hold,
   input  logic [W-1:0] period,
   output logic         tick
);

   logic [W-1:0] cnt;

   assign tick = (cnt == period);

   // clear wins over hold; otherwise count up and wrap to 0 on expiry
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (!hold) begin
         if (tick)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: FSM + count register stepping from load_val to target_val.
// Optional auto-reload build: define COUNTER_SEQUENCER_AUTORELOAD_EN to add the
// `reload` input; on reaching target the count is reloaded the following cycle
// and the sequence keeps running.
module counter_sequencer
   import counter_seq_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  dir_down,
   input  logic [WIDTH-1:0]      load_val,
   input  logic [WIDTH-1:0]      target_val,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  pause,
   input  logic                  abort,
`ifdef COUNTER_SEQUENCER_AUTORELOAD_EN
   input  logic                  reload,
`endif
   output logic                  en,
   output logic [WIDTH-1:0]      count,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            state
);

   state_t                  st;
   logic                    dir_l;
   logic [WIDTH-1:0]        target_l;
   logic [PRESCALE_W-1:0]   prescale_l;
   logic                    tick;
   logic                    start_ok;
   logic                    reload_now;
   logic [WIDTH-1:0]        nxt;

   assign state    = st;
   assign busy     = (st == RUN) || (st == PAUSE);
   assign start_ok = start && ((st == IDLE) || (st == DONE));
   assign nxt      = dir_l ? count - 1'b1 : count + 1'b1;

`ifdef COUNTER_SEQUENCER_AUTORELOAD_EN
   logic             reload_l;
   logic [WIDTH-1:0] load_l;
   // reload happens in the cycle the done pulse is visible, still in RUN
   assign reload_now = (st == RUN) && done && reload_l;
`else
   assign reload_now = 1'b0;
`endif

   // prescaler only advances in RUN without pause; restarts on start/abort/reload
   prescale_tick #(.W(PRESCALE_W)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .clear  (abort || start_ok || reload_now),
      .hold   ((st != RUN) || pause),
      .period (prescale_l),
      .tick   (tick)
   );

   // sequencing FSM; en/done are single-cycle registered pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= IDLE;
         count      <= '0;
         en         <= 1'b0;
         done       <= 1'b0;
         dir_l      <= 1'b0;
         target_l   <= '0;
         prescale_l <= '0;
`ifdef COUNTER_SEQUENCER_AUTORELOAD_EN
         reload_l   <= 1'b0;
         load_l     <= '0;
`endif
      end else begin
         en   <= 1'b0;
         done <= 1'b0;
         if (abort)
            st <= IDLE;
         else begin
            case (st)
               IDLE, DONE: begin
                  if (start) begin
                     count      <= load_val;
                     dir_l      <= dir_down;
                     target_l   <= target_val;
                     prescale_l <= prescale;
`ifdef COUNTER_SEQUENCER_AUTORELOAD_EN
                     reload_l   <= reload;
                     load_l     <= load_val;
`endif
                     if (load_val == target_val) begin
                        st   <= DONE;
                        done <= 1'b1;
                     end else
                        st <= RUN;
                  end
               end
               RUN: begin
`ifdef COUNTER_SEQUENCER_AUTORELOAD_EN
                  if (reload_now)
                     count <= load_l;
                  else
`endif
                  if (pause)
                     st <= PAUSE;
                  else if (tick) begin
                     en    <= 1'b1;
                     count <= nxt;
                     if (nxt == target_l) begin
                        done <= 1'b1;
`ifdef COUNTER_SEQUENCER_AUTORELOAD_EN
                        if (!reload_l)
                           st <= DONE;
`else
                        st <= DONE;
`endif
                     end
                  end
               end
               PAUSE: begin
                  if (!pause)
                     st <= RUN;
               end
               default: st <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer (WIDTH=8, PRESCALE_W=16).
module tb_counter_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, dir_down, pause, abort;
   logic [7:0]  load_val, target_val;
   logic [15:0] prescale;
   logic        en, busy, done;
   logic [7:0]  count;
   logic [1:0]  state;
   int          total = 0;
   int          bad   = 0;
`ifdef COUNTER_SEQUENCER_AUTORELOAD_EN
   logic        reload = 1'b0;
`endif

   counter_sequencer #(.WIDTH(8), .PRESCALE_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dir_down   (dir_down),
      .load_val   (load_val),
      .target_val (target_val),
      .prescale   (prescale),
      .pause      (pause),
      .abort      (abort),
`ifdef COUNTER_SEQUENCER_AUTORELOAD_EN
      .reload     (reload),
`endif
      .en         (en),
      .count      (count),
      .busy       (busy),
      .done       (done),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // advance one edge, sample 1ns later
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic setup(input logic [7:0] ld, input logic [7:0] tg, input logic dn,
                        input logic [15:0] ps);
      load_val = ld; target_val = tg; dir_down = dn; prescale = ps; start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 0; dir_down = 0; pause = 0; abort = 0;
      load_val = 0; target_val = 0; prescale = 0;
      #2;
      chk("rst_state", state, 0); chk("rst_count", count, 0);
      chk("rst_en", en, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      @(negedge clk); rst = 1'b0;
      cyc();

      // up 3 -> 7, step every cycle
      setup(8'd3, 8'd7, 1'b0, 16'd0);
      chk("t1_state", state, 1); chk("t1_count0", count, 3); chk("t1_en0", en, 0);
      chk("t1_busy", busy, 1);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         chk("t1_count", count, 3 + i); chk("t1_en", en, 1);
         chk("t1_done", done, (i == 4) ? 1 : 0);
      end
      chk("t1_state_done", state, 3); chk("t1_busy_end", busy, 0);
      cyc();
      chk("t1_done_once", done, 0); chk("t1_en_off", en, 0); chk("t1_hold", count, 7);

      // down 10 -> 8, prescale 2
      setup(8'd10, 8'd8, 1'b1, 16'd2);
      chk("t2_count0", count, 10);
      for (int i = 1; i <= 6; i++) begin
         cyc();
         chk("t2_en", en, (i % 3 == 0) ? 1 : 0);
         chk("t2_count", count, 10 - i / 3);
         chk("t2_done", done, (i == 6) ? 1 : 0);
      end
      chk("t2_state", state, 3);
      cyc();
      chk("t2_done_once", done, 0);

      // wrap 254 -> 1 upward
      setup(8'd254, 8'd1, 1'b0, 16'd0);
      for (int i = 1; i <= 3; i++) begin
         cyc();
         chk("t3_count", count, (254 + i) % 256); chk("t3_en", en, 1);
         chk("t3_done", done, (i == 3) ? 1 : 0);
      end
      cyc();
      chk("t3_en_after", en, 0); chk("t3_state", state, 3);

      // pause mid-interval with prescale 3, then abort
      setup(8'd0, 8'd100, 1'b0, 16'd3);
      cyc(); cyc();
      chk("t4_pre_en", en, 0);
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("t4_paused_state", state, 2); chk("t4_paused_en", en, 0);
         chk("t4_paused_busy", busy, 1);
      end
      pause = 1'b0;
      cyc(); chk("t4_resume_state", state, 1); chk("t4_resume_en", en, 0);
      cyc(); chk("t4_wait_en", en, 0); chk("t4_wait_count", count, 0);
      cyc(); chk("t4_step_en", en, 1); chk("t4_step_count", count, 1);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk("t4_abort_state", state, 0); chk("t4_abort_count", count, 1);
      chk("t4_abort_done", done, 0); chk("t4_abort_en", en, 0);

      // load == target
      setup(8'd5, 8'd5, 1'b0, 16'd0);
      chk("t5_state", state, 3); chk("t5_done", done, 1); chk("t5_en", en, 0);
      chk("t5_count", count, 5);
      cyc(); chk("t5_done_once", done, 0);

      // start during RUN ignored; abort beats start
      setup(8'd20, 8'd30, 1'b0, 16'd0);
      load_val = 8'd50; start = 1'b1;
      cyc();
      chk("t6_ign_count", count, 21); chk("t6_ign_state", state, 1);
      abort = 1'b1;
      cyc();
      abort = 1'b0; start = 1'b0;
      chk("t6_abort_state", state, 0); chk("t6_abort_count", count, 21);

      // async reset between edges mid-RUN
      setup(8'd0, 8'd200, 1'b0, 16'd0);
      cyc(); cyc();
      chk("t7_pre_count", count, 2); chk("t7_pre_en", en, 1);
      #2 rst = 1'b1;
      #1;
      chk("t7_rst_count", count, 0); chk("t7_rst_state", state, 0);
      chk("t7_rst_en", en, 0); chk("t7_rst_busy", busy, 0);
      #1 rst = 1'b0;
      cyc();
      chk("t7_post_state", state, 0); chk("t7_post_count", count, 0);

`ifdef COUNTER_SEQUENCER_AUTORELOAD_EN
      // auto-reload 0 -> 2: count 1,2,0,1,2 with done on each 2
      reload = 1'b1;
      setup(8'd0, 8'd2, 1'b0, 16'd0);
      reload = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         cyc();
         chk("t8_count", count, (i % 3 == 1) ? 1 : ((i % 3 == 2) ? 2 : 0));
         chk("t8_done", done, (i % 3 == 2) ? 1 : 0);
         chk("t8_en", en, (i % 3 == 0) ? 0 : 1);
         chk("t8_state", state, 1);
      end
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk("t8_abort_state", state, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
